sequence_detector: RTL and testbench

//   Serial-bit pattern detector for the serial transmitter datapath.
//   - Samples one input bit J on every rising Clk.
//   - Raises W for exactly one cycle after the pattern 1-1-1-0-1 (MSB first) has been received.
//   - Overlapping matches are detected.
//   - Moore FSM: W depends only on the state register.

---
 rtl/seq_det_pkg.sv | 23 ++
 rtl/seq_match_counter.sv | 26 ++
 rtl/sequence_detector.sv | 61 ++++++
 tb/tb_sequence_detector.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: state encoding,
// the fixed pattern and the match-counter geometry.
// The optional match counter is enabled by defining SEQDET_COUNT_EN.
package seq_det_pkg;

  // Three-bit state encoding; codes 6 and 7 are unused and recover to S0.
  typedef enum logic [2:0] {
    S0 = 3'd0,  // nothing matched
    S1 = 3'd1,  // "1"
    S2 = 3'd2,  // "11"
    S3 = 3'd3,  // "111" (longer runs of 1s park here)
    S4 = 3'd4,  // "1110"
    S5 = 3'd5   // "11101" matched
  } state_e;

  // Pattern recognised by the FSM, MSB received first.
  localparam logic [4:0] PATTERN = 5'b11101;

  // Match counter width and saturation value.
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

endpackage : seq_det_pkg

// File: rtl/seq_match_counter.sv
// Saturating match counter for the serial pattern detector.
// Counts one per assertion of inc, holds at its maximum, cleared by srst.
// Only instantiated when SEQDET_COUNT_EN is defined.
module seq_match_counter
  import seq_det_pkg::*;
(
  input  logic             clk,
  input  logic             srst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg = '0;

  // Count matches, holding at the ceiling instead of wrapping.
  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule : seq_match_counter

// File: rtl/sequence_detector.sv
// Moore FSM that detects the serial pattern 1-1-1-0-1 on J, overlaps
// allowed. W is a pure decode of the state register, so it is glitch-free
// and high for exactly the cycle following the edge that samples the final 1.
// Defining SEQDET_COUNT_EN adds the saturating MatchCnt output.
module sequence_detector
  import seq_det_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic             J,
  output logic             W
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CNT_W-1:0] MatchCnt
`endif
);

  // Power-up value puts the FSM in S0 so W is low before any reset pulse.
  state_e state_reg = S0;
  state_e state_next;

  // State register; reset dominates J and discards any partial match.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg <= S0;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; S5 on a 1 goes to S2 because the trailing 1 of the
  // match plus the new 1 form the "11" prefix of the next occurrence.
  always_comb begin
    state_next = S0;
    case (state_reg)
      S0:      state_next = J ? S1 : S0;
      S1:      state_next = J ? S2 : S0;
      S2:      state_next = J ? S3 : S0;
      S3:      state_next = J ? S3 : S4;
      S4:      state_next = J ? S5 : S0;
      S5:      state_next = J ? S2 : S0;
      default: state_next = S0;
    endcase
  end

  assign W = (state_reg == S5);

`ifdef SEQDET_COUNT_EN
  // A match is counted on the edge that moves the FSM into S5.
  logic enter_s5;
  assign enter_s5 = (state_next == S5) && !Rst;

  seq_match_counter u_counter (
    .clk   (Clk),
    .srst  (Rst),
    .inc   (enter_s5),
    .count (MatchCnt)
  );
`endif

endmodule : sequence_detector

// File: tb/tb_sequence_detector.sv
// Bench for sequence_detector. The reference model keeps the bits received
// since the last reset and flags a match whenever the five most recent bits
// equal 1-1-1-0-1; it counts matches with saturation at 255.
module tb_sequence_detector;

  localparam time PERIOD = 200ns;
  localparam logic [4:0] PAT = 5'b11101;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       J   = 1'b0;
  logic       W;
`ifdef SEQDET_COUNT_EN
  logic [7:0] MatchCnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  bit   hist[$];
  logic exp_w   = 1'b0;
  int   exp_cnt = 0;

  always #(PERIOD/2) Clk = ~Clk;

  sequence_detector dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .J        (J),
    .W        (W)
`ifdef SEQDET_COUNT_EN
    ,
    .MatchCnt (MatchCnt)
`endif
  );

  // Drive one bit 10 ns before the rising edge, then update the model and
  // return #1 after the edge so the caller can sample the outputs.
  task automatic drive(input logic j, input logic r);
    logic [4:0] last5;
    @(negedge Clk);
    #(PERIOD/2 - 10ns);
    J   = j;
    Rst = r;
    @(posedge Clk);
    #1;
    if (r) begin
      hist.delete();
      exp_w   = 1'b0;
      exp_cnt = 0;
    end else begin
      hist.push_back(j);
      exp_w = 1'b0;
      if (hist.size() >= 5) begin
        for (int k = 0; k < 5; k++) last5[4-k] = hist[hist.size()-5+k];
        exp_w = (last5 == PAT);
      end
      if (exp_w && exp_cnt < 255) exp_cnt++;
    end
  endtask

  task automatic test_reset;
    // No reset pulse yet: W must already be low.
    #1;
    compared++;
    if (W !== 1'b0) begin
      mismatched++;
      $display("FAIL power_up_w: got %b expected 0", W);
    end
  endtask

  task automatic test_no_reset_stream;
    logic [11:0] bits = 12'b1010_1111_1010; // bit 11 sent first
    logic [11:0] wexp = 12'b0000_0000_0010; // pulse only after 11th bit
    for (int i = 11; i >= 0; i--) begin
      drive(bits[i], 1'b0);
      compared++;
      if (W !== exp_w || W !== wexp[i]) begin
        mismatched++;
        $display("FAIL stream1 bit%0d: got W=%b expected %b", 12 - i, W, wexp[i]);
      end
    end
  endtask

  task automatic test_overlap;
    logic [9:0] bits = 10'b1110_1110_10;
    logic [9:0] wexp = 10'b0000_1000_10;
    drive(1'b0, 1'b1);
    for (int i = 9; i >= 0; i--) begin
      drive(bits[i], 1'b0);
      compared++;
      if (W !== exp_w || W !== wexp[i]) begin
        mismatched++;
        $display("FAIL overlap bit%0d: got W=%b expected %b", 10 - i, W, wexp[i]);
      end
    end
  endtask

  task automatic test_long_ones;
    drive(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0);
      compared++;
      if (W !== 1'b0) begin
        mismatched++;
        $display("FAIL ones_run cycle%0d: got W=%b expected 0", i, W);
      end
    end
    drive(1'b0, 1'b0);
    compared++;
    if (W !== 1'b0) begin
      mismatched++;
      $display("FAIL ones_then0: got W=%b expected 0", W);
    end
    drive(1'b1, 1'b0);
    compared++;
    if (W !== 1'b1 || exp_w !== 1'b1) begin
      mismatched++;
      $display("FAIL ones_then01: got W=%b expected 1", W);
    end
    drive(1'b0, 1'b0);
    compared++;
    if (W !== 1'b0) begin
      mismatched++;
      $display("FAIL ones_pulse_end: got W=%b expected 0", W);
    end
  endtask

  task automatic test_mid_reset;
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);  // reset wins over J=1 that would complete the match
    compared++;
    if (W !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_rst: got W=%b expected 0", W);
    end
    drive(1'b1, 1'b0);
    compared++;
    if (W !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_after: got W=%b expected 0", W);
    end
    // Pattern must now need a full fresh 11101 (one 1 already received).
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    compared++;
    if (W !== 1'b1) begin
      mismatched++;
      $display("FAIL midreset_restart: got W=%b expected 1", W);
    end
    drive(1'b1, 1'b1);  // reset while in S5
    compared++;
    if (W !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_in_s5: got W=%b expected 0", W);
    end
  endtask

  task automatic test_random;
    logic j, r;
    for (int i = 0; i < 3000; i++) begin
      j = ($urandom_range(99) < 70);
      r = ($urandom_range(199) == 0);
      drive(j, r);
      compared++;
      if (W !== exp_w) begin
        mismatched++;
        $display("FAIL random cyc%0d: J=%b Rst=%b got W=%b expected %b", i, j, r, W, exp_w);
      end
`ifdef SEQDET_COUNT_EN
      compared++;
      if (MatchCnt !== 8'(exp_cnt)) begin
        mismatched++;
        $display("FAIL random_cnt cyc%0d: got %0d expected %0d", i, MatchCnt, exp_cnt);
      end
`endif
    end
  endtask

`ifdef SEQDET_COUNT_EN
  task automatic test_count_saturate;
    logic [4:0] p = PAT;
    drive(1'b0, 1'b1);
    compared++;
    if (MatchCnt !== 8'h00) begin
      mismatched++;
      $display("FAIL cnt_reset: got %0d expected 0", MatchCnt);
    end
    for (int m = 0; m < 260; m++) begin
      for (int b = 4; b >= 0; b--) drive(p[b], 1'b0);
      compared++;
      if (MatchCnt !== 8'(exp_cnt)) begin
        mismatched++;
        $display("FAIL cnt_match%0d: got %0d expected %0d", m + 1, MatchCnt, exp_cnt);
      end
    end
    compared++;
    if (MatchCnt !== 8'hFF) begin
      mismatched++;
      $display("FAIL cnt_saturated: got %0d expected 255", MatchCnt);
    end
    drive(1'b1, 1'b1);
    compared++;
    if (MatchCnt !== 8'h00) begin
      mismatched++;
      $display("FAIL cnt_cleared: got %0d expected 0", MatchCnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_no_reset_stream();
    test_overlap();
    test_long_ones();
    test_mid_reset();
`ifdef SEQDET_COUNT_EN
    test_count_saturate();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_sequence_detector
